// File: rtl/instrom_pkg.sv
// Shared definitions for the instruction ROM arbiter and the instrom wrapper.
package instrom_pkg;

    // Byte address of ROM word 0.
    localparam logic [31:0] PC_BASE_ADDR_DEF = 32'h8000_0000;

    // ROM geometry, shared with the instrom wrapper.
    localparam int unsigned ROM_DEPTH_DEF = 32;
    localparam int unsigned ROM_AW_DEF    = $clog2(ROM_DEPTH_DEF);

    // Arbiter FSM: one ROM access outstanding at a time.
    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } arb_state_e;

endpackage

// File: rtl/instrom_arbiter_if.sv
// Bundle of the two requester ports and the ROM read port around instrom_arbiter.
// master: the surrounding system (core ports plus ROM wrapper); slave: the arbiter.
interface instrom_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ROM_AW = instrom_pkg::ROM_AW_DEF
);
    // Port 0: instruction fetch
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_err;
    logic              m0_rready;

    // Port 1: read-only data loads
    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_err;
    logic              m1_rready;

    // ROM read port
    logic              rom_ren;
    logic [ROM_AW-1:0] rom_addr;
    logic [DATA_W-1:0] rom_rdata;

    modport master (
        output m0_req, m0_addr, m0_rready,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_addr, m1_rready,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  rom_ren, rom_addr,
        output rom_rdata
    );

    modport slave (
        input  m0_req, m0_addr, m0_rready,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_addr, m1_rready,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output rom_ren, rom_addr,
        input  rom_rdata
    );

endinterface

// File: rtl/instrom_arb_pick.sv
// Two-requester grant logic producing a one-hot grant.
// Build option INSTROM_ARB_RR_EN: round-robin with a last-granted pointer;
// otherwise fixed priority with port 0 (fetch) winning contention.
module instrom_arb_pick (
`ifdef INSTROM_ARB_RR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef INSTROM_ARB_RR_EN
    // Last-granted port; resets to 1 so port 0 wins the first contention.
    logic ptr_q;

    // Uncontended requests pass straight through; on contention the other port wins.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = ptr_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // Pointer follows every grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b1;
        end else if (|gnt) begin
            ptr_q <= gnt[1];
        end
    end
`else
    // Port 0 always wins; port 1 only when port 0 is idle.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0]) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end
`endif

endmodule

// File: rtl/instrom_arbiter.sv
// Shares the single instruction ROM read port between fetch (port 0) and
// read-only data loads (port 1). One access outstanding; addresses are checked
// for alignment and range before the ROM is touched; responses are held until
// the owner accepts them.
// Build option INSTROM_ARB_RR_EN selects round-robin arbitration (default: fixed).
module instrom_arbiter
    import instrom_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       DATA_W       = 32,
    parameter logic [ADDR_W-1:0] PC_BASE_ADDR = PC_BASE_ADDR_DEF,
    parameter int unsigned       ROM_DEPTH    = ROM_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    instrom_arbiter_if.slave   bus
);

    localparam int unsigned       ROM_AW    = $clog2(ROM_DEPTH);
    localparam logic [ADDR_W-1:0] ROM_BYTES = ADDR_W'(ROM_DEPTH * 4);

    arb_state_e        state_q;
    logic              owner_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              pick_en;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              granting;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] off;
    logic              bad;
    logic              owner_rready;

    // Grants only from IDLE and never while reset is held.
    assign pick_en = rst_n && (state_q == StIdle);
    assign req     = {bus.m1_req, bus.m0_req};

    instrom_arb_pick u_pick (
`ifdef INSTROM_ARB_RR_EN
        .clk   (clk),
        .rst_n (rst_n),
`endif
        .en    (pick_en),
        .req   (req),
        .gnt   (gnt)
    );

    // Address check of the granted port and ROM read issue in the grant cycle.
    always_comb begin
        granting = |gnt;
        sel_addr = gnt[1] ? bus.m1_addr : bus.m0_addr;
        // Below-base addresses wrap to a huge offset and fail the range test.
        off      = sel_addr - PC_BASE_ADDR;
        bad      = (sel_addr[1:0] != 2'b00) || (off >= ROM_BYTES);
        bus.m0_gnt   = gnt[0];
        bus.m1_gnt   = gnt[1];
        bus.rom_ren  = granting && !bad;
        bus.rom_addr = bus.rom_ren ? off[ROM_AW+1:2] : '0;
    end

    // Response is presented only to the owner; the other port sees all zeros.
    always_comb begin
        bus.m0_rvalid = (state_q == StResp) && !owner_q;
        bus.m1_rvalid = (state_q == StResp) &&  owner_q;
        bus.m0_rdata  = bus.m0_rvalid ? rdata_q : '0;
        bus.m1_rdata  = bus.m1_rvalid ? rdata_q : '0;
        bus.m0_err    = bus.m0_rvalid && err_q;
        bus.m1_err    = bus.m1_rvalid && err_q;
        owner_rready  = owner_q ? bus.m1_rready : bus.m0_rready;
    end

    // Access FSM with owner and response register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (granting) begin
                        owner_q <= gnt[1];
                        if (bad) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state_q <= StResp;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    rdata_q <= bus.rom_rdata;
                    err_q   <= 1'b0;
                    state_q <= StResp;
                end
                StResp: begin
                    // Return to IDLE only; the next grant waits a cycle.
                    if (owner_rready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
